// File: rtl/freq_meas_pkg.sv
// Shared encodings and default sizing for the frequency counter and its display path.
package freq_meas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      GATE  = 2'd2,
      LATCH = 2'd3
   } state_t;

   localparam int TICK_DIV_DEF = 100000;
   localparam int GATE_W_DEF   = 16;
   localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into timebase ticks; one tick pulse every TICK_DIV enabled cycles.
module tick_prescaler
   import freq_meas_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)           cnt <= '0;
      else if (clear || tick) cnt <= '0;
      else if (enable)        cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gate-time sequencer: opens a gate of N timebase ticks, counts sig_in rising edges,
// and hands the latched count to the display side with a valid/ack handshake.
module freq_meas_ctrl
   import freq_meas_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int GATE_W   = GATE_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [GATE_W-1:0] gate_ticks,
   input  logic              sig_in,
   input  logic              result_ack,
   output logic              busy,
   output logic              gate_open,
   output logic [CNT_W-1:0]  result,
   output logic              result_valid,
   output logic              overflow,
   output logic              overrun
);

   state_t            state, state_nx;
   logic              s1, s2, s3, rise, tick, sat, latch;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state == SETUP),
      .enable  (state == GATE),
      .tick    (tick)
   );

   assign busy      = (state != IDLE);
   assign gate_open = (state == GATE);
   assign rise      = s2 & ~s3;
   assign latch     = (state == LATCH) && !abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SETUP;
         SETUP:   state_nx = GATE;
         GATE:    if (tick && gate_cnt == GATE_W'(1)) state_nx = LATCH;
         LATCH:   state_nx = continuous ? SETUP : IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort && state != IDLE) state_nx = IDLE;
   end

   // A zero gate length is run as a single tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (state == SETUP) begin
         gate_cnt <= (gate_ticks == '0) ? GATE_W'(1) : gate_ticks;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (state == GATE) begin
         if (tick) gate_cnt <= gate_cnt - 1'b1;
         if (rise) begin
            if (&edge_cnt) sat      <= 1'b1;
            else           edge_cnt <= edge_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result       <= '0;
         overflow     <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (latch) begin
         result       <= edge_cnt;
         overflow     <= sat;
         result_valid <= 1'b1;
         if (result_valid && !result_ack) overrun <= 1'b1;
      end else if (result_ack && result_valid) begin
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end
   end

endmodule
